seg7_scan_driver: RTL and testbench
===================================

// Module: seg7_scan_driver
// PURPOSE
//   Parametrised multiplexed 7-segment driver for NUM_DIGITS BCD digits. Scans one digit per
//   slot with a built-in refresh prescaler and adds leading-zero blanking, decimal points,
//   per-digit blink, configurable output polarity and a frame-start pulse.
//   Sits between the time-formatting logic (BCD minutes/seconds) and the board display pins.
// PARAMETERS
//   NUM_DIGITS      4       digits scanned; must be >= 2
//   REFRESH_DIV     100000  clk cycles per digit slot; must be >= 1
//   BLINK_DIV       64      full frames per blink half-period; must be >= 1
//   SEG_ACTIVE_LOW  1       1: seg/dp_out are 0 = lit; 0: 1 = lit
//   AN_ACTIVE_LOW   1       1: an bit 0 = digit enabled; 0: 1 = enabled
// PORTS
//   clk         in   1             system clock
//   rst         in   1             synchronous, active-high reset
//   bcd         in   4*NUM_DIGITS  digit i = bcd[4i+3:4i]; digit 0 is rightmost
//   dp          in   NUM_DIGITS    decimal point request per digit
//   blank_lz    in   1             1 = enable leading-zero blanking
//   blink_mask  in   NUM_DIGITS    1 = digit blinks
//   seg         out  7             segments {g,f,e,d,c,b,a}, polarity per SEG_ACTIVE_LOW
//   dp_out      out  1             decimal point segment, polarity per SEG_ACTIVE_LOW
//   an          out  NUM_DIGITS    one-hot digit enable, polarity per AN_ACTIVE_LOW
//   frame_tick  out  1             1-cycle pulse when a new frame starts on digit 0
// BEHAVIOUR
//   - Reset (wins over everything, also mid-frame): prescaler=0, idx=0, frame_cnt=0,
//     blink_phase=0. All outputs registered; in reset: an all disabled, seg and dp_out unlit,
//     frame_tick=0. The first edge after rst drops drives digit 0. frame_tick does not
//     pulse for this first frame.
//   - Prescaler counts 0..REFRESH_DIV-1. At REFRESH_DIV-1 it wraps to 0 and idx advances.
//     idx wraps from NUM_DIGITS-1 to 0. Each digit is driven for exactly REFRESH_DIV cycles.
//     REFRESH_DIV=1 advances every cycle.
//   - On the idx wrap NUM_DIGITS-1 -> 0: frame_tick=1 for one cycle, coincident with the
//     first cycle of an selecting digit 0. frame_cnt counts these wraps 0..BLINK_DIV-1;
//     on its wrap blink_phase toggles.
//   - Outputs are registered from the current idx and live inputs, so input changes appear
//     one clock later. an, seg and dp_out always update on the same edge (no ghosting).
//   - Decode (active-high gfedcba): 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F.
//     Codes 10..15 show a dash (40). SEG_ACTIVE_LOW inverts seg and dp_out.
//   - Leading-zero blank: with blank_lz=1, digit i (i>0) is blanked when bcd digits
//     i..NUM_DIGITS-1 are all 0 AND dp[j]=0 for all j>=i. Digit 0 is never LZ-blanked.
//   - Blink: when blink_phase=1 and blink_mask[idx]=1, the digit is blanked.
//   - A blanked digit (LZ or blink) keeps its time slot, but an stays all disabled and
//     seg/dp_out stay unlit for that slot.
//   - Otherwise exactly one an bit is enabled. dp_out is lit iff dp[idx]=1.
//   - Counter widths: $clog2 of range, min 1 bit. No other state.
// TESTING (NUM_DIGITS=4, REFRESH_DIV=2, BLINK_DIV=2, both polarities active-low)
//   1. rst=1 for 3 cycles -> an=1111, seg=1111111, dp_out=1, frame_tick=0.
//      On the first edge after release -> an=1110.
//   2. bcd=16'h1234, blank_lz=0 -> an sequence 1110,1101,1011,0111, each held 2 cycles.
//      Digit 0 slot: seg=0011001; digit 3 slot: seg=1111001.
//      frame_tick pulses every 8 cycles together with an=1110.
//   3. bcd=16'h0050, blank_lz=1 -> digit-3/2 slots: an=1111. Digit 1: seg=0010010;
//      digit 0: seg=1000000. With bcd=0, only the digit-0 slot has an active.
//   4. bcd=0, dp=4'b0100, blank_lz=1 -> digit 3 blanked. Digits 2,1,0 show 1000000.
//      dp_out=0 only in the digit-2 slot.
//   5. blink_mask=4'b0001 -> digit 0 visible in frames 0-1, an=1111 in its slot for
//      frames 2-3, visible again in frames 4-5. Other digits are unaffected.
//   6. Digit 0 = 4'hC -> seg=0111111 (dash). Assert rst while idx=2 -> next edge all off.
//      After release, the scan restarts at digit 0 with the prescaler at 0.

Source files
------------

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver
// Multiplexed 7-segment driver for NUM_DIGITS BCD digits. It drives one digit per
// time slot, with a refresh prescaler setting the slot length. It also provides
// leading-zero blanking, decimal points, per-digit blink, selectable pin polarity
// and a pulse that marks the start of each frame. Every output is registered, so
// anodes and segments change on the same clock edge.
module seg7_scan_driver #(
  parameter int NUM_DIGITS     = 4,
  parameter int REFRESH_DIV    = 100000,
  parameter int BLINK_DIV      = 64,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit AN_ACTIVE_LOW  = 1'b1
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [4*NUM_DIGITS-1:0] bcd_i,
  input  logic [NUM_DIGITS-1:0]   dp_i,
  input  logic                    blank_lz_i,
  input  logic [NUM_DIGITS-1:0]   blink_mask_i,
  output logic [6:0]              seg_o,
  output logic                    dp_out_o,
  output logic [NUM_DIGITS-1:0]   an_o,
  output logic                    frame_tick_o
);

  localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int FW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  localparam logic [PW-1:0] PRE_MAX = PW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0] IDX_MAX = IW'(NUM_DIGITS - 1);
  localparam logic [FW-1:0] FRM_MAX = FW'(BLINK_DIV - 1);

  localparam logic [6:0]            SEG_OFF = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic                  DP_OFF  = SEG_ACTIVE_LOW;
  localparam logic [NUM_DIGITS-1:0] AN_OFF  = AN_ACTIVE_LOW ? {NUM_DIGITS{1'b1}}
                                                            : {NUM_DIGITS{1'b0}};

  logic [PW-1:0]         prescaler_q, prescaler_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [FW-1:0]         frame_cnt_q, frame_cnt_d;
  logic                  blink_phase_q, blink_phase_d;
  logic                  tick_pending_q, tick_pending_d;
  logic [6:0]            seg_q, seg_d;
  logic                  dp_out_q, dp_out_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic                  frame_tick_q, frame_tick_d;

  logic                  slot_end;
  logic                  frame_end;
  logic [3:0]            cur_digit;
  logic                  cur_dp;
  logic                  cur_blink;
  logic                  higher_nonzero;
  logic                  lz_blank;
  logic                  blink_blank;
  logic                  blanked;
  logic [NUM_DIGITS-1:0] an_onehot;
  logic [6:0]            seg_lit;
  logic                  dp_lit;

  // Active-high gfedcba patterns. The non-decimal codes 10..15 show a single dash.
  function automatic logic [6:0] decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h3F;
      4'd1:    s = 7'h06;
      4'd2:    s = 7'h5B;
      4'd3:    s = 7'h4F;
      4'd4:    s = 7'h66;
      4'd5:    s = 7'h6D;
      4'd6:    s = 7'h7D;
      4'd7:    s = 7'h07;
      4'd8:    s = 7'h7F;
      4'd9:    s = 7'h6F;
      default: s = 7'h40;
    endcase
    return s;
  endfunction

  // Scan timing: prescaler -> digit index -> frame counter -> blink phase.
  // A wrap from the last digit back to digit 0 is held for one cycle in
  // tick_pending. The frame pulse then lines up with the first registered
  // digit-0 output, not with the index change that precedes it.
  always_comb begin
    slot_end       = (prescaler_q == PRE_MAX);
    frame_end      = slot_end && (idx_q == IDX_MAX);
    prescaler_d    = slot_end ? '0 : prescaler_q + 1'b1;
    idx_d          = idx_q;
    frame_cnt_d    = frame_cnt_q;
    blink_phase_d  = blink_phase_q;
    tick_pending_d = frame_end;
    if (slot_end) begin
      idx_d = frame_end ? '0 : idx_q + 1'b1;
    end
    if (frame_end) begin
      if (frame_cnt_q == FRM_MAX) begin
        frame_cnt_d   = '0;
        blink_phase_d = ~blink_phase_q;
      end else begin
        frame_cnt_d = frame_cnt_q + 1'b1;
      end
    end
  end

  // Select the digit for the current slot and decide whether it is blanked.
  // The leading-zero check looks at this digit and every more-significant digit.
  // A set decimal point counts as content, so it stops the blanking.
  always_comb begin
    cur_digit      = '0;
    cur_dp         = 1'b0;
    cur_blink      = 1'b0;
    higher_nonzero = 1'b0;
    an_onehot      = '0;
    for (int j = 0; j < NUM_DIGITS; j++) begin
      if (IW'(j) == idx_q) begin
        cur_digit    = bcd_i[4*j +: 4];
        cur_dp       = dp_i[j];
        cur_blink    = blink_mask_i[j];
        an_onehot[j] = 1'b1;
      end
      if ((IW'(j) >= idx_q) && ((bcd_i[4*j +: 4] != 4'd0) || dp_i[j])) begin
        higher_nonzero = 1'b1;
      end
    end
    lz_blank     = blank_lz_i && (idx_q != '0) && !higher_nonzero;
    blink_blank  = blink_phase_q && cur_blink;
    blanked      = lz_blank || blink_blank;
    seg_lit      = blanked ? 7'h00 : decode(cur_digit);
    dp_lit       = !blanked && cur_dp;
    seg_d        = SEG_ACTIVE_LOW ? ~seg_lit : seg_lit;
    dp_out_d     = SEG_ACTIVE_LOW ? ~dp_lit : dp_lit;
    an_d         = blanked ? AN_OFF : (AN_ACTIVE_LOW ? ~an_onehot : an_onehot);
    frame_tick_d = tick_pending_q;
  end

  // Counter and output registers. Reset blanks the display and restarts the scan at digit 0.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      prescaler_q    <= '0;
      idx_q          <= '0;
      frame_cnt_q    <= '0;
      blink_phase_q  <= 1'b0;
      tick_pending_q <= 1'b0;
      seg_q          <= SEG_OFF;
      dp_out_q       <= DP_OFF;
      an_q           <= AN_OFF;
      frame_tick_q   <= 1'b0;
    end else begin
      prescaler_q    <= prescaler_d;
      idx_q          <= idx_d;
      frame_cnt_q    <= frame_cnt_d;
      blink_phase_q  <= blink_phase_d;
      tick_pending_q <= tick_pending_d;
      seg_q          <= seg_d;
      dp_out_q       <= dp_out_d;
      an_q           <= an_d;
      frame_tick_q   <= frame_tick_d;
    end
  end

  assign seg_o        = seg_q;
  assign dp_out_o     = dp_out_q;
  assign an_o         = an_q;
  assign frame_tick_o = frame_tick_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Testbench for seg7_scan_driver: 4 digits, 2-cycle slots, 2-frame blink period,
// active-low segments and anodes. Stimulus queues the expected outputs for each
// cycle. A separate monitor compares those entries against the DUT on falling edges.
module tb_seg7_scan_driver;

  localparam logic [6:0] SEG_OFF = 7'b1111111;
  localparam logic [6:0] SEG0    = 7'b1000000;
  localparam logic [6:0] SEG1    = 7'b1111001;
  localparam logic [6:0] SEG2    = 7'b0100100;
  localparam logic [6:0] SEG3    = 7'b0110000;
  localparam logic [6:0] SEG4    = 7'b0011001;
  localparam logic [6:0] SEG5    = 7'b0010010;
  localparam logic [6:0] DASH    = 7'b0111111;
  localparam logic [3:0] AN_OFF  = 4'b1111;
  localparam logic [3:0] AN_SEL [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] bcd = '0;
  logic [3:0]  dp = '0;
  logic        blankLz = 1'b0;
  logic [3:0]  blinkMask = '0;
  logic [6:0]  seg;
  logic        dpOut;
  logic [3:0]  an;
  logic        frameTick;

  int cyc = 0;
  int relCyc = 0;
  int testsRun = 0;
  int testsFailed = 0;

  typedef struct {
    int         cyc;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       tick;
    string      tag;
  } expT;

  expT expQ[$];
  expT monE;

  seg7_scan_driver #(
    .NUM_DIGITS(4),
    .REFRESH_DIV(2),
    .BLINK_DIV(2),
    .SEG_ACTIVE_LOW(1'b1),
    .AN_ACTIVE_LOW(1'b1)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bcd_i(bcd),
    .dp_i(dp),
    .blank_lz_i(blankLz),
    .blink_mask_i(blinkMask),
    .seg_o(seg),
    .dp_out_o(dpOut),
    .an_o(an),
    .frame_tick_o(frameTick)
  );

  // 10 ns clock
  always #5 clk = ~clk;

  // Cycle counter: value n means n rising edges have occurred
  always @(posedge clk) cyc <= cyc + 1;

  // Queue one expected output set for the cycle relCyc + n
  task automatic pushExp(input int n, input logic [3:0] anV, input logic [6:0] segV,
                         input logic dpV, input logic tickV, input string tag);
    expT e;
    e.cyc  = relCyc + n;
    e.an   = anV;
    e.seg  = segV;
    e.dp   = dpV;
    e.tick = tickV;
    e.tag  = tag;
    expQ.push_back(e);
  endtask

  // Queue whole frames. Each slot gets the hand-computed segment code; digits
  // in blankT expect all anodes off, and digits in dpT expect a lit decimal
  // point. Each slot lasts 2 cycles, so a frame is 8 cycles, and every frame
  // after the first begins with a tick.
  task automatic pushFrames(input int firstFrame, input int nFrames,
                            input logic [6:0] s0, input logic [6:0] s1,
                            input logic [6:0] s2, input logic [6:0] s3,
                            input logic [3:0] blankT, input logic [3:0] dpT,
                            input string tag);
    logic [6:0] segT [4];
    segT[0] = s0;
    segT[1] = s1;
    segT[2] = s2;
    segT[3] = s3;
    for (int n = 8*firstFrame + 1; n <= 8*(firstFrame + nFrames); n++) begin
      int slot;
      slot = ((n - 1) / 2) % 4;
      pushExp(n, blankT[slot] ? AN_OFF : AN_SEL[slot],
              blankT[slot] ? SEG_OFF : segT[slot],
              !(dpT[slot] && !blankT[slot]),
              (n > 1) && ((n - 1) % 8 == 0), tag);
    end
  endtask

  task automatic runCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Apply inputs while holding reset, then release it. relCyc marks the release point.
  task automatic applyStimulus(input logic [15:0] bcdV, input logic [3:0] dpV,
                               input logic lzV, input logic [3:0] blinkV,
                               input int rstCycles);
    @(negedge clk);
    bcd       = bcdV;
    dp        = dpV;
    blankLz   = lzV;
    blinkMask = blinkV;
    rst       = 1'b1;
    relCyc    = cyc;
    for (int k = 1; k <= rstCycles; k++) pushExp(k, AN_OFF, SEG_OFF, 1'b1, 1'b0, "reset");
    runCycles(rstCycles);
    rst    = 1'b0;
    relCyc = cyc;
  endtask

  task automatic checkField(input string tag, input string field, input int c,
                            input logic [6:0] act, input logic [6:0] req);
    testsRun++;
    if (act !== req) begin
      testsFailed++;
      $display("[TB] FAIL %s.%s cycle %0d: got %b, expected %b", tag, field, c, act, req);
    end
  endtask

  task automatic checkOutput(input expT e);
    checkField(e.tag, "an", e.cyc, {3'b000, an}, {3'b000, e.an});
    checkField(e.tag, "seg", e.cyc, seg, e.seg);
    checkField(e.tag, "dp_out", e.cyc, {6'b0, dpOut}, {6'b0, e.dp});
    checkField(e.tag, "frame_tick", e.cyc, {6'b0, frameTick}, {6'b0, e.tick});
  endtask

  // Monitor: compare each queued expectation at the falling edge of its cycle
  always @(negedge clk) begin
    while (expQ.size() > 0 && expQ[0].cyc <= cyc) begin
      monE = expQ.pop_front();
      if (monE.cyc < cyc) begin
        testsRun++;
        testsFailed++;
        $display("[TB] FAIL %s missed: cycle %0d, now %0d", monE.tag, monE.cyc, cyc);
      end else begin
        checkOutput(monE);
      end
    end
  end

  // Watchdog so a stalled run still ends with a visible failure
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    // Reset for 3 cycles, then scan 1234 with no blanking across two frames
    applyStimulus(16'h1234, 4'b0000, 1'b0, 4'b0000, 3);
    pushFrames(0, 2, SEG4, SEG3, SEG2, SEG1, 4'b0000, 4'b0000, "scan1234");
    runCycles(16);

    // Leading zeros of 0050 are blanked
    applyStimulus(16'h0050, 4'b0000, 1'b1, 4'b0000, 2);
    pushFrames(0, 1, SEG0, SEG5, SEG_OFF, SEG_OFF, 4'b1100, 4'b0000, "lz0050");
    runCycles(8);

    // All zeros: only digit 0 remains visible
    applyStimulus(16'h0000, 4'b0000, 1'b1, 4'b0000, 2);
    pushFrames(0, 1, SEG0, SEG_OFF, SEG_OFF, SEG_OFF, 4'b1110, 4'b0000, "lzzero");
    runCycles(8);

    // A decimal point on digit 2 keeps digits 2..0 visible
    applyStimulus(16'h0000, 4'b0100, 1'b1, 4'b0000, 2);
    pushFrames(0, 1, SEG0, SEG0, SEG0, SEG_OFF, 4'b1000, 4'b0100, "lzdp");
    runCycles(8);

    // Blink digit 0: visible in frames 0-1, dark in 2-3, visible again in 4-5
    applyStimulus(16'h1234, 4'b0000, 1'b0, 4'b0001, 2);
    pushFrames(0, 2, SEG4, SEG3, SEG2, SEG1, 4'b0000, 4'b0000, "blinkon");
    pushFrames(2, 2, SEG4, SEG3, SEG2, SEG1, 4'b0001, 4'b0000, "blinkoff");
    pushFrames(4, 2, SEG4, SEG3, SEG2, SEG1, 4'b0000, 4'b0000, "blinkback");
    runCycles(48);

    // Dash for code C, then a mid-frame reset while digit 2 is being scanned
    applyStimulus(16'h123C, 4'b0000, 1'b0, 4'b0000, 2);
    pushExp(1, 4'b1110, DASH, 1'b1, 1'b0, "dash");
    pushExp(2, 4'b1110, DASH, 1'b1, 1'b0, "dash");
    pushExp(5, 4'b1011, SEG2, 1'b1, 1'b0, "preRst");
    pushExp(6, AN_OFF, SEG_OFF, 1'b1, 1'b0, "midRst");
    runCycles(5);
    rst = 1'b1;
    runCycles(1);
    rst    = 1'b0;
    relCyc = cyc;
    pushExp(1, 4'b1110, DASH, 1'b1, 1'b0, "restart");
    pushExp(2, 4'b1110, DASH, 1'b1, 1'b0, "restart");
    pushExp(3, 4'b1101, SEG3, 1'b1, 1'b0, "restart");
    runCycles(5);

    testsRun++;
    if (expQ.size() != 0) begin
      testsFailed++;
      $display("[TB] FAIL drain: got %0d pending, expected 0", expQ.size());
    end
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
